// File: rtl/spu_alu_pkg.sv
// rtl/spu_alu_pkg.sv - shared types and constants for the SPU ALU arbiter
package spu_alu_pkg;

    localparam int DEFAULT_OP_WIDTH = 6;
    localparam int MAX_REQ          = 8;

    localparam logic [DEFAULT_OP_WIDTH-1:0] SPU_ALU_NOP = 6'd0;

    // One stage of the in-flight tracker; id is wide enough for MAX_REQ requesters.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } alu_tag_t;

    function automatic logic [2:0] toTagId(input int unsigned idx);
        return 3'(idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IDW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        // Scan cyclically from ptr; the first valid requester wins.
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/spu_alu_arbiter.sv
// rtl/spu_alu_arbiter.sv - round-robin sharing of one SPU ALU with tagged in-order responses
module spu_alu_arbiter
    import spu_alu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int OP_WIDTH    = DEFAULT_OP_WIDTH,
    parameter int ALU_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [OP_WIDTH-1:0]           alu_op,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = ALU_LATENCY + 1;

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gntId;
    logic [NUM_REQ-1:0] gnt;
    logic               transfer;
    alu_tag_t           issueTag;
    alu_tag_t           outTag;
    alu_tag_t           tagPipe [DEPTH];
    logic               unusedTagBits;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gntId)
    );

    assign req_ready = gnt;
    assign transfer  = |gnt;

    always_comb begin
        issueTag       = '0;
        issueTag.valid = transfer;
        issueTag.id    = transfer ? toTagId(32'(gntId)) : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= OP_WIDTH'(SPU_ALU_NOP);
            alu_a  <= '0;
            alu_b  <= '0;
            ptr    <= '0;
        end else if (transfer) begin
            alu_op <= req_op[gntId*OP_WIDTH +: OP_WIDTH];
            alu_a  <= req_a[gntId*DATA_WIDTH +: DATA_WIDTH];
            alu_b  <= req_b[gntId*DATA_WIDTH +: DATA_WIDTH];
            ptr    <= (gntId == IDW'(NUM_REQ - 1)) ? '0 : gntId + 1'b1;
        end else begin
            // Operands hold so the ALU inputs only toggle on real work.
            alu_op <= OP_WIDTH'(SPU_ALU_NOP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                tagPipe[k] <= '0;
            end
        end else begin
            tagPipe[0] <= issueTag;
            for (int k = 1; k < DEPTH; k++) begin
                tagPipe[k] <= tagPipe[k-1];
            end
        end
    end

    assign outTag        = tagPipe[DEPTH-1];
    assign unusedTagBits = ^outTag.id;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | tagPipe[k].valid;
        end
    end

    // The output-stage tag lines up with the ALU result for the op it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (outTag.valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= outTag.id[IDW-1:0];
            rsp_data  <= alu_result;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spu_alu_arbiter.sv
// tb/tb_spu_alu_arbiter.sv - scoreboard bench for spu_alu_arbiter
module tb_spu_alu_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int OW  = 6;
    localparam int LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          req_valid = '0;
    logic [NR-1:0]          req_ready;
    logic [NR*OW-1:0]       req_op = '0;
    logic [NR*DW-1:0]       req_a = '0;
    logic [NR*DW-1:0]       req_b = '0;
    logic [OW-1:0]          alu_op;
    logic [DW-1:0]          alu_a;
    logic [DW-1:0]          alu_b;
    logic [DW-1:0]          alu_result = '0;
    logic                   rsp_valid;
    logic [$clog2(NR)-1:0]  rsp_id;
    logic [DW-1:0]          rsp_data;
    logic                   busy;

    spu_alu_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU with one-edge latency: 4 = add, 20 = sub.
    always @(posedge clk) begin
        case (alu_op)
            6'd4:    alu_result <= alu_a + alu_b;
            6'd20:   alu_result <= alu_a - alu_b;
            default: alu_result <= '0;
        endcase
    end

    typedef struct {
        int id;
        int data;
        int due;
    } exp_t;

    exp_t sbq[$];
    exp_t monE;
    int   total = 0;
    int   bad = 0;
    int   modelPtr = 0;

    logic [NR-1:0] curValid = '0;
    logic [OW-1:0] curOp [NR];
    logic [DW-1:0] curA [NR];
    logic [DW-1:0] curB [NR];
    int            waitCnt [NR];

    function automatic int refAlu(input int op, input int a, input int b);
        if (op == 4)  return (a + b) & 255;
        if (op == 20) return (a - b) & 255;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of requests, predict the grant, push the expected response.
    task automatic applyCycle(output int g);
        logic [NR-1:0] expReady;
        int            r;
        for (int i = 0; i < NR; i++) begin
            req_op[i*OW +: OW] = curOp[i];
            req_a[i*DW +: DW]  = curA[i];
            req_b[i*DW +: DW]  = curB[i];
        end
        req_valid = curValid;
        #1;
        g = -1;
        for (int i = 0; i < NR; i++) begin
            r = (modelPtr + i) % NR;
            if (g < 0 && curValid[r]) g = r;
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(expReady));
        if (g >= 0) begin
            sbq.push_back('{g, refAlu(int'(curOp[g]), int'(curA[g]), int'(curB[g])), cyc + LAT + 2});
            modelPtr = (g + 1) % NR;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d data=%0d, required no response", rsp_id, rsp_data);
            end else begin
                monE = sbq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(monE.id));
                check("rsp_data", 32'(rsp_data), 32'(monE.data));
                check("rsp_cycle", 32'(cyc), 32'(monE.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_rsp: got none by cycle %0d, required id=%0d data=%0d at cycle %0d",
                     cyc, sbq[0].id, sbq[0].data, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    int g;
    int worst;

    initial begin
        for (int i = 0; i < NR; i++) begin
            curOp[i] = '0; curA[i] = '0; curB[i] = '0; waitCnt[i] = 0;
        end

        repeat (3) @(negedge clk);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester.
        curValid = 2'b01; curOp[0] = 6'd4; curA[0] = 8'd12; curB[0] = 8'd10;
        applyCycle(g);
        curValid = '0;
        check("single_alu_op", 32'(alu_op), 4);
        check("single_alu_a", 32'(alu_a), 12);
        check("single_alu_b", 32'(alu_b), 10);
        check("single_busy", 32'(busy), 1);
        repeat (3) applyCycle(g);

        // Contention: both held valid.
        curOp[0] = 6'd4;  curA[0] = 8'd12; curB[0] = 8'd10;
        curOp[1] = 6'd20; curA[1] = 8'd12; curB[1] = 8'd10;
        curValid = 2'b11;
        worst = -1;
        for (int n = 0; n < 4; n++) begin
            applyCycle(g);
            if (worst >= 0) check("contention_alternate", 32'(g != worst), 1);
            worst = g;
        end
        curValid = '0;
        check("contention_alu_op", 32'(alu_op), (worst == 0) ? 4 : 20);
        check("contention_busy", 32'(busy), 1);

        // Idle gap.
        applyCycle(g);
        check("idle1_alu_op", 32'(alu_op), 0);
        check("idle1_busy", 32'(busy), 1);
        applyCycle(g);
        check("idle2_alu_op", 32'(alu_op), 0);
        check("idle2_busy", 32'(busy), 0);
        applyCycle(g);
        check("idle3_rsp_valid", 32'(rsp_valid), 0);
        check("idle3_busy", 32'(busy), 0);

        // Reset while an op is in flight.
        curValid = 2'b10; curOp[1] = 6'd4; curA[1] = 8'd1; curB[1] = 8'd1;
        applyCycle(g);
        curValid = '0;
        req_valid = '0;
        rst_n = 1'b0;
        sbq.delete();
        modelPtr = 0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_alu_op", 32'(alu_op), 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_rsp_valid", 32'(rsp_valid), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        curOp[0] = 6'd4;  curA[0] = 8'd12; curB[0] = 8'd10;
        curOp[1] = 6'd20; curA[1] = 8'd12; curB[1] = 8'd10;
        curValid = 2'b11;
        applyCycle(g);
        check("postrst_first_grant", 32'(g), 0);
        curValid = 2'b10;
        applyCycle(g);
        curValid = '0;
        repeat (3) applyCycle(g);

        // Random fairness sweep.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!curValid[i] && $urandom_range(0, 1) == 1) begin
                    curValid[i] = 1'b1;
                    curOp[i] = ($urandom_range(0, 1) == 1) ? 6'd4 : 6'd20;
                    curA[i]  = DW'($urandom);
                    curB[i]  = DW'($urandom);
                end
            end
            applyCycle(g);
            worst = 0;
            for (int i = 0; i < NR; i++) begin
                if (i == g) begin
                    curValid[i] = 1'b0;
                    waitCnt[i] = 0;
                end else if (curValid[i]) begin
                    waitCnt[i]++;
                end
                if (waitCnt[i] > worst) worst = waitCnt[i];
            end
            check("wait_bound", 32'(worst <= NR - 1), 1);
        end

        curValid = '0;
        repeat (5) applyCycle(g);
        check("scoreboard_empty", 32'(sbq.size()), 0);
        check("final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
